reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, out-of-order CDB completion,
// one in-order retirement per cycle with registered commit/store/flush pulses.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 issue_signal,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd_id,
  input  logic                 issue_pred_jump,
  output logic [ROB_WIDTH-1:0] issue_tag,
  output logic                 rob_full,
  input  logic                 cdb_signal,
  input  logic [ROB_WIDTH-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  input  logic                 cdb_jump,
  input  logic [ROB_WIDTH-1:0] query_tag_1,
  input  logic [ROB_WIDTH-1:0] query_tag_2,
  output logic                 query_ready_1,
  output logic                 query_ready_2,
  output logic [31:0]          query_value_1,
  output logic [31:0]          query_value_2,
  output logic                 rob_commit_signal,
  output logic [31:0]          commit_rd_value,
  output logic [4:0]           commit_rd_id,
  output logic [ROB_WIDTH-1:0] commit_rd_tag,
  output logic                 store_commit_signal,
  output logic [ROB_WIDTH-1:0] store_commit_tag,
  output logic                 clear_signal,
  output logic [31:0]          correct_pc
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam int CNT_W = ROB_WIDTH + 1;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_BRANCH = 2'd1,
    TYPE_STORE  = 2'd2,
    TYPE_RSVD   = 2'd3
  } rob_type_e;

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DEPTH-1:0]     busy_q, busy_d, ready_q, ready_d;

  rob_type_e   type_q  [DEPTH];
  logic [4:0]  rd_q    [DEPTH];
  logic        pred_q  [DEPTH];
  logic        jump_q  [DEPTH];
  logic [31:0] value_q [DEPTH];

  logic                 commit_sig_q, store_sig_q, clear_q;
  logic [31:0]          commit_value_q, correct_pc_q;
  logic [4:0]           commit_id_q;
  logic [ROB_WIDTH-1:0] commit_tag_q, store_tag_q;

  logic      do_issue, do_retire, do_cdb, mispredict, commit_fire, store_fire;
  rob_type_e head_type;
  logic      cdb_hit_1, cdb_hit_2;

  assign rob_full  = (count_q == CNT_W'(DEPTH));
  assign issue_tag = tail_q;
  assign head_type = type_q[head_q];

  // A flush on the retiring branch wins over any issue or CDB write this edge.
  assign do_retire   = rdy_in & busy_q[head_q] & ready_q[head_q];
  assign mispredict  = do_retire & (head_type == TYPE_BRANCH) & (jump_q[head_q] != pred_q[head_q]);
  assign commit_fire = do_retire & (head_type == TYPE_REG);
  assign store_fire  = do_retire & (head_type == TYPE_STORE);
  assign do_issue    = rdy_in & issue_signal & ~rob_full & ~mispredict;
  assign do_cdb      = rdy_in & cdb_signal & busy_q[cdb_tag] & ~mispredict;

  assign cdb_hit_1     = cdb_signal & (cdb_tag == query_tag_1);
  assign cdb_hit_2     = cdb_signal & (cdb_tag == query_tag_2);
  assign query_ready_1 = (busy_q[query_tag_1] & ready_q[query_tag_1]) | cdb_hit_1;
  assign query_ready_2 = (busy_q[query_tag_2] & ready_q[query_tag_2]) | cdb_hit_2;
  assign query_value_1 = cdb_hit_1 ? cdb_value : value_q[query_tag_1];
  assign query_value_2 = cdb_hit_2 ? cdb_value : value_q[query_tag_2];

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_cdb) begin
      ready_d[cdb_tag] = 1'b1;
    end
    if (do_retire) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = head_q + ROB_WIDTH'(1);
    end
    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d          = tail_q + ROB_WIDTH'(1);
    end
    unique case ({do_issue, do_retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q  <= '0;
      ready_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; busy/ready gate every read that matters.
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      type_q[tail_q] <= rob_type_e'(issue_type);
      rd_q[tail_q]   <= issue_rd_id;
      pred_q[tail_q] <= issue_pred_jump;
    end
    if (do_cdb) begin
      value_q[cdb_tag] <= cdb_value;
      jump_q[cdb_tag]  <= cdb_jump;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_sig_q   <= 1'b0;
      store_sig_q    <= 1'b0;
      clear_q        <= 1'b0;
      commit_value_q <= '0;
      commit_id_q    <= '0;
      commit_tag_q   <= '0;
      store_tag_q    <= '0;
      correct_pc_q   <= '0;
    end else begin
      commit_sig_q <= commit_fire;
      store_sig_q  <= store_fire;
      clear_q      <= mispredict;
      if (commit_fire) begin
        commit_value_q <= value_q[head_q];
        commit_id_q    <= rd_q[head_q];
        commit_tag_q   <= head_q;
      end
      if (store_fire) begin
        store_tag_q <= head_q;
      end
      if (mispredict) begin
        correct_pc_q <= value_q[head_q];
      end
    end
  end

  assign rob_commit_signal   = commit_sig_q;
  assign commit_rd_value     = commit_value_q;
  assign commit_rd_id        = commit_id_q;
  assign commit_rd_tag       = commit_tag_q;
  assign store_commit_signal = store_sig_q;
  assign store_commit_tag    = store_tag_q;
  assign clear_signal        = clear_q;
  assign correct_pc          = correct_pc_q;

endmodule
